// File: rtl/cbp_gshare_param.sv
// Parametrised conditional branch predictor: bimodal or gshare indexed table of
// saturating counters, speculative global history with execute-stage repair.
module cbp_gshare_param #(
  parameter int PC_W   = 32,
  parameter int HIST_W = 8,
  parameter int IDX_W  = 8,
  parameter int CTR_W  = 2,
  parameter int MODE   = 1,
  parameter int STAT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              f_valid_i,
  input  logic              f_stall_i,
  input  logic [PC_W-1:0]   f_pc_i,
  output logic              f_predict_o,
  output logic [HIST_W-1:0] f_history_o,
  input  logic              ex_valid_i,
  input  logic              ex_mispredict_i,
  input  logic              ex_taken_i,
  input  logic [HIST_W-1:0] ex_history_i,
  input  logic              wb_valid_i,
  input  logic [PC_W-1:0]   wb_pc_i,
  input  logic [HIST_W-1:0] wb_history_i,
  input  logic              wb_taken_i,
  input  logic              wb_predict_i,
  output logic [STAT_W-1:0] stat_branch_o,
  output logic [STAT_W-1:0] stat_miss_o
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [CTR_W-1:0]  pht_q [DEPTH];
  logic [HIST_W-1:0] ghr_q;
  logic [STAT_W-1:0] stat_branch_q;
  logic [STAT_W-1:0] stat_miss_q;

  logic [IDX_W-1:0]  f_idx;
  logic [IDX_W-1:0]  wb_idx;
  logic [CTR_W-1:0]  f_ctr;
  logic [CTR_W-1:0]  wb_ctr;
  logic [CTR_W-1:0]  wb_ctr_next;
  logic              unused_pc;

  function automatic logic [IDX_W-1:0] pht_index(input logic [PC_W-1:0]   pc,
                                                 input logic [HIST_W-1:0] hist);
    logic [IDX_W-1:0] pc_idx;
    pc_idx = pc[IDX_W+1:2];
    if (MODE == 0) return pc_idx;
    else           return pc_idx ^ IDX_W'(hist);
  endfunction

  assign f_idx  = pht_index(f_pc_i, ghr_q);
  assign wb_idx = pht_index(wb_pc_i, wb_history_i);
  assign f_ctr  = pht_q[f_idx];
  assign wb_ctr = pht_q[wb_idx];

  // PC bits outside the index field (alignment and upper bits) are don't-care.
  assign unused_pc = ^{f_pc_i, wb_pc_i};

  assign f_predict_o   = f_ctr[CTR_W-1];
  assign f_history_o   = ghr_q;
  assign stat_branch_o = stat_branch_q;
  assign stat_miss_o   = stat_miss_q;

  always_comb begin
    wb_ctr_next = wb_ctr;
    if (wb_taken_i) begin
      if (wb_ctr != {CTR_W{1'b1}}) wb_ctr_next = wb_ctr + CTR_W'(1);
    end else begin
      if (wb_ctr != '0) wb_ctr_next = wb_ctr - CTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CTR_INIT;
    end else if (wb_valid_i) begin
      pht_q[wb_idx] <= wb_ctr_next;
    end
  end

  // Truncating {hist, bit} to HIST_W drops the oldest bit; also covers HIST_W=1.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (ex_valid_i && ex_mispredict_i) begin
      ghr_q <= HIST_W'({ex_history_i, ex_taken_i});
    end else if (f_valid_i && !f_stall_i) begin
      ghr_q <= HIST_W'({ghr_q, f_predict_o});
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      stat_branch_q <= '0;
      stat_miss_q   <= '0;
    end else if (wb_valid_i) begin
      if (stat_branch_q != {STAT_W{1'b1}}) stat_branch_q <= stat_branch_q + STAT_W'(1);
      if ((wb_predict_i != wb_taken_i) && (stat_miss_q != {STAT_W{1'b1}}))
        stat_miss_q <= stat_miss_q + STAT_W'(1);
    end
  end

endmodule
